fir_nsum_csa: RTL and testbench
===============================

# fir_nsum_csa

Parametrised N-tap moving-sum (boxcar) filter that generalises the fixed 4-tap carry-save summer. It is configurable in sample width, tap count, signedness and pipeline depth, and adds a runtime tap-length select, an input valid qualifier and an output valid flag. Internally it is a sample shift register feeding a masked 3:2 carry-save tree and one final carry-propagate adder. It sits in the datapath test harness as the drop-in replacement for the 4-tap summer.

## Interface
- W, default 16: input sample width.
- N, default 8: maximum tap count, 2 ≤ N ≤ 64.
- SIGNED, default 1: 1 = two's-complement samples (sign-extended), 0 = unsigned (zero-extended).
- PIPE, default 0: 0 = CPA output registered once; 1 = extra register between CSA tree and CPA.
- Derived OW = W + clog2(N): output width.
- LW = clog2(N)+1: length field width.
- clk  in  1  sole clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  qualifies a; the sample is accepted on a posedge with in_valid=1.
- a  in  W  input sample.
- len  in  LW  active tap count, sampled on accepted beats.
- s  out  OW  sum of the len most recent accepted samples.
- out_valid  out  1  s holds a fully-warmed sum for a new beat.

## Operation
- Tap shift register tap[0..N-1], W bits each. On an accepted beat: tap[0]<=a, tap[k]<=tap[k-1]. It holds when in_valid=0.
- len_r register, loaded on accepted beats with a clamped value:
  - len=0 is treated as 1.
  - len>N is treated as N.
- Mask: tap k contributes 0 when k ≥ len_r. Otherwise it contributes sign- or zero-extended to OW bits.
- CSA tree: repeated 3:2 reduction of the N masked operands to a sum/carry pair, then one OW-bit CPA. All arithmetic is modulo 2^OW. No overflow is possible at full N.
- fill counter, 0..N: increments on accepted beats and saturates at N.
- Warm condition: fill ≥ len_r, both evaluated after the current beat's update.
- out_valid pulses for exactly one cycle per accepted beat whose warm condition holds.
- s updates only on such valid beats and holds its value otherwise, including during bubbles and warm-up.
- Changing len: takes effect from the next accepted beat. It does not clear fill, so shortening len can assert out_valid immediately.
- Reset:
  - all taps = 0, len_r = N, fill = 0, s = 0, out_valid = 0;
  - pipeline registers cleared;
  - reset has priority over a simultaneous in_valid.
- Reset mid-stream discards all in-flight beats. No out_valid appears until len fresh samples have been accepted.

## Timing
- PIPE=0: a beat accepted at edge E shifts the taps at E. s and out_valid update at E+1. This is the same a→s latency as the 4-tap summer (input reg + output reg).
- PIPE=1: the CSA sum/carry pair and the valid bit are registered at E+1. s and out_valid update at E+2.
- Throughput is one sample per cycle. There is no backpressure: the block is always ready.
- Critical path:
  - PIPE=0: the CSA tree of depth ceil(log1.5(N/2)) plus the OW-bit CPA.
  - PIPE=1: the path is split at the CSA/CPA boundary.
- Back-to-back beats after warm-up give out_valid high every cycle.

## Structure
- Package fir_pkg holds:
  - function for OW/LW derivation (clog2);
  - function for len clamp;
  - typedef for the sign-extension helper.
- One sub-module: csa32_row, a parametrised-width row of full adders. It takes x, y, z and produces sum and carry, with carry shifted left by one.
- The top level generates the tree by instantiating csa32_row levels until two operands remain. The CPA is behavioural (+).
- fill, len_r and the valid pipeline stay in the top level.

## Test plan
Default parameters W=16, N=8, SIGNED=1, PIPE=0 unless stated.
- Warm-up: reset, len=8, stream 1..8 contiguously → out_valid first high one cycle after sample 8, s=36. Sample 9 → s=44.
- Bubbles: the same stream with in_valid=0 on alternate cycles → identical s sequence, s held and out_valid=0 on bubble cycles.
- Signed extremes:
  - eight beats of −32768 → s = −262144 (19-bit 0x40000);
  - eight beats of 32767 → s = 262136;
  - SIGNED=0 with 0xFFFF ×8 → s = 524280.
- Runtime len:
  - warmed, len=4, samples 10,20,30,40 → s=100 on the fourth beat;
  - then len=0, sample 7 → s=7;
  - then len=15 (clamped to 8) → sum of last 8.
- Reset mid-stream after 5 beats → next cycle s=0 and out_valid=0. With len=8, out_valid stays 0 until 8 new beats.
- PIPE=1 with the warm-up stream → s=36 and out_valid two cycles after sample 8. The result sequence otherwise matches PIPE=0.

Source files
------------

// File: rtl/fir_nsum_csa_pkg.sv
// Shared helpers for the moving-sum filter: width derivation, length clamp and
// carry-save tree shape.
package fir_pkg;

  typedef enum logic {EXT_ZERO = 1'b0, EXT_SIGN = 1'b1} ext_mode_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int calc_ow(input int w, input int n);
    return w + clog2(n);
  endfunction

  function automatic int calc_lw(input int n);
    return clog2(n) + 1;
  endfunction

  function automatic int clamp_len(input int l, input int n);
    if (l == 0) return 1;
    if (l > n) return n;
    return l;
  endfunction

  // Operand count after one 3:2 level: each full triple becomes two, leftovers pass.
  function automatic int csa_next(input int cnt);
    return 2 * (cnt / 3) + (cnt % 3);
  endfunction

  function automatic int csa_count(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = csa_next(c);
    return c;
  endfunction

  function automatic int csa_levels(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    while (c > 2) begin
      c = csa_next(c);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/fir_nsum_csa_if.sv
// Sample/result bundle of the moving-sum filter.
interface fir_nsum_csa_if
  import fir_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 8
);
  localparam int OW = calc_ow(W, N);
  localparam int LW = calc_lw(N);

  logic          in_valid;
  logic [W-1:0]  a;
  logic [LW-1:0] len;
  logic [OW-1:0] s;
  logic          out_valid;

  modport master (output in_valid, a, len, input s, out_valid);
  modport slave  (input in_valid, a, len, output s, out_valid);
endinterface

// File: rtl/fir_nsum_csa_csa32_row.sv
// One row of full adders: three operands in, sum and left-shifted carry out.
module csa32_row #(
  parameter int WD = 16
) (
  input  logic [WD-1:0] x,
  input  logic [WD-1:0] y,
  input  logic [WD-1:0] z,
  output logic [WD-1:0] sum,
  output logic [WD-1:0] carry
);
  logic [WD-1:0] maj;

  assign sum   = x ^ y ^ z;
  assign maj   = (x & y) | (x & z) | (y & z);
  assign carry = {maj[WD-2:0], 1'b0};
endmodule

// File: rtl/fir_nsum_csa.sv
// N-tap boxcar summer: tap shift register, masked 3:2 carry-save tree, one CPA,
// runtime length select and warm-up gated output valid.
module fir_nsum_csa
  import fir_pkg::*;
#(
  parameter int W      = 16,
  parameter int N      = 8,
  parameter int SIGNED = 1,
  parameter int PIPE   = 0
) (
  input logic           clk,
  input logic           reset,
  fir_nsum_csa_if.slave bus
);
  localparam int        OW   = calc_ow(W, N);
  localparam int        LW   = calc_lw(N);
  localparam int        NLEV = csa_levels(N);
  localparam ext_mode_e EXT  = (SIGNED != 0) ? EXT_SIGN : EXT_ZERO;

  logic [W-1:0]  tap_q [N];
  logic [W-1:0]  tap_d [N];
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] fill_q, fill_d;
  logic          v0_q, v0_d;
  logic [OW-1:0] psum_q, psum_d;
  logic [OW-1:0] pcar_q, pcar_d;
  logic          pv_q, pv_d;
  logic [OW-1:0] s_q, s_d;
  logic          ov_q, ov_d;

  logic [OW-1:0] ops [NLEV+1][N];
  logic [OW-1:0] fin_sum;
  logic          fin_v;

  for (genvar k = 0; k < N; k++) begin : g_mask
    logic ext_bit;
    assign ext_bit   = (EXT == EXT_SIGN) && tap_q[k][W-1];
    assign ops[0][k] = (int'(len_q) > k) ? {{(OW-W){ext_bit}}, tap_q[k]} : '0;
  end

  for (genvar l = 0; l < NLEV; l++) begin : g_lvl
    localparam int CNT  = csa_count(N, l);
    localparam int GRP  = CNT / 3;
    localparam int NEXT = csa_next(CNT);
    for (genvar g = 0; g < GRP; g++) begin : g_row
      csa32_row #(.WD(OW)) u_row (
        .x    (ops[l][3*g]),
        .y    (ops[l][3*g+1]),
        .z    (ops[l][3*g+2]),
        .sum  (ops[l+1][2*g]),
        .carry(ops[l+1][2*g+1])
      );
    end
    for (genvar r = 0; r < CNT % 3; r++) begin : g_pass
      assign ops[l+1][2*GRP+r] = ops[l][3*GRP+r];
    end
    for (genvar u = NEXT; u < N; u++) begin : g_idle
      assign ops[l+1][u] = '0;
    end
  end

  always_comb begin
    tap_d  = tap_q;
    len_d  = len_q;
    fill_d = fill_q;
    if (bus.in_valid) begin
      tap_d[0] = bus.a;
      for (int k = 1; k < N; k++) tap_d[k] = tap_q[k-1];
      len_d = LW'(clamp_len(int'(bus.len), N));
      if (fill_q != LW'(N)) fill_d = fill_q + 1'b1;
    end
    // Warm test uses the post-update fill and length of this beat.
    v0_d = bus.in_valid && (fill_d >= len_d);

    psum_d = ops[NLEV][0];
    pcar_d = ops[NLEV][1];
    pv_d   = v0_q;

    if (PIPE != 0) begin
      fin_v   = pv_q;
      fin_sum = psum_q + pcar_q;
    end else begin
      fin_v   = v0_q;
      fin_sum = ops[NLEV][0] + ops[NLEV][1];
    end
    ov_d = fin_v;
    s_d  = fin_v ? fin_sum : s_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) tap_q[k] <= '0;
      len_q  <= LW'(N);
      fill_q <= '0;
      v0_q   <= 1'b0;
      psum_q <= '0;
      pcar_q <= '0;
      pv_q   <= 1'b0;
      s_q    <= '0;
      ov_q   <= 1'b0;
    end else begin
      tap_q  <= tap_d;
      len_q  <= len_d;
      fill_q <= fill_d;
      v0_q   <= v0_d;
      psum_q <= psum_d;
      pcar_q <= pcar_d;
      pv_q   <= pv_d;
      s_q    <= s_d;
      ov_q   <= ov_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.out_valid = ov_q;
endmodule

// File: tb/tb_fir_nsum_csa.sv
// Bench for the moving-sum filter: three instances (signed/PIPE=0, signed/PIPE=1,
// unsigned/PIPE=0) share one stimulus stream and are compared against a history model.
module tb_fir_nsum_csa;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int OW = 19;
  localparam longint MASK = (64'd1 << OW) - 1;

  typedef struct {
    logic          rst;
    logic          iv;
    logic [W-1:0]  a;
    logic [3:0]    len;
    logic          ov;
    logic [OW-1:0] s;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic iv;
  logic [W-1:0] a_in;
  logic [3:0]   len_in;

  int total = 0;
  int bad   = 0;

  fir_nsum_csa_if #(.W(W), .N(N)) if0 ();
  fir_nsum_csa_if #(.W(W), .N(N)) if1 ();
  fir_nsum_csa_if #(.W(W), .N(N)) if2 ();

  assign if0.in_valid = iv;  assign if0.a = a_in;  assign if0.len = len_in;
  assign if1.in_valid = iv;  assign if1.a = a_in;  assign if1.len = len_in;
  assign if2.in_valid = iv;  assign if2.a = a_in;  assign if2.len = len_in;

  fir_nsum_csa #(.W(W), .N(N), .SIGNED(1), .PIPE(0)) dut0 (.clk(clk), .reset(rst), .bus(if0.slave));
  fir_nsum_csa #(.W(W), .N(N), .SIGNED(1), .PIPE(1)) dut1 (.clk(clk), .reset(rst), .bus(if1.slave));
  fir_nsum_csa #(.W(W), .N(N), .SIGNED(0), .PIPE(0)) dut2 (.clk(clk), .reset(rst), .bus(if2.slave));

  always #5 clk = ~clk;

  // Reference state: newest accepted sample first; zeros stand for cleared taps.
  int     hist [N];
  int     m_len;
  int     m_cnt;
  logic   bv_a, bv_b;
  longint bs_a, bs_b, bu_a;
  logic   e_ov0, e_ov1, e_ov2;
  longint e_s0, e_s1, e_s2;

  vec_t tbl[$];

  function automatic longint win_sum(input int l, input bit sgn);
    longint acc;
    acc = 0;
    for (int k = 0; k < l; k++)
      acc += sgn ? longint'(hist[k] >= 32768 ? hist[k] - 65536 : hist[k]) : longint'(hist[k]);
    return acc & MASK;
  endfunction

  task automatic model_edge(input logic r, input logic v, input int a, input int l);
    if (r) begin
      for (int k = 0; k < N; k++) hist[k] = 0;
      m_len = N; m_cnt = 0;
      bv_a = 0; bv_b = 0; bs_a = 0; bs_b = 0; bu_a = 0;
      e_ov0 = 0; e_ov1 = 0; e_ov2 = 0; e_s0 = 0; e_s1 = 0; e_s2 = 0;
    end else begin
      e_ov0 = bv_a; if (bv_a) e_s0 = bs_a;
      e_ov2 = bv_a; if (bv_a) e_s2 = bu_a;
      e_ov1 = bv_b; if (bv_b) e_s1 = bs_b;
      bv_b = bv_a; bs_b = bs_a;
      bv_a = 0;
      if (v) begin
        for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = a;
        m_len = (l == 0) ? 1 : (l > N ? N : l);
        if (m_cnt < N) m_cnt++;
        bv_a = (m_cnt >= m_len);
        bs_a = win_sum(m_len, 1'b1);
        bu_a = win_sum(m_len, 1'b0);
      end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input int a, input int l);
    rst = r; iv = v; a_in = W'(a); len_in = 4'(l);
    @(posedge clk);
    model_edge(r, v, a, l);
    #1;
    chk("m0_ov", longint'(if0.out_valid), longint'(e_ov0));
    chk("m0_s",  longint'(if0.s), e_s0);
    chk("m1_ov", longint'(if1.out_valid), longint'(e_ov1));
    chk("m1_s",  longint'(if1.s), e_s1);
    chk("m2_ov", longint'(if2.out_valid), longint'(e_ov2));
    chk("m2_s",  longint'(if2.s), e_s2);
  endtask

  function automatic void add(input logic r, input logic v, input int a, input int l,
                              input logic ov, input int s);
    vec_t t;
    t.rst = r; t.iv = v; t.a = W'(a); t.len = 4'(l); t.ov = ov; t.s = OW'(s);
    tbl.push_back(t);
  endfunction

  initial begin
    rst = 1'b1; iv = 1'b0; a_in = '0; len_in = 4'd8;

    // Expected columns describe dut0 right after the row's edge.
    add(1, 0, 0, 8, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 1, k, 8, 0, 0);
    add(0, 1, 9, 8, 1, 36);
    add(0, 0, 0, 8, 1, 44);
    add(0, 0, 0, 8, 0, 44);
    add(0, 1, 10, 4, 0, 44);
    add(0, 1, 20, 4, 1, 34);
    add(0, 1, 30, 4, 1, 47);
    add(0, 1, 40, 4, 1, 69);
    add(0, 0, 0, 4, 1, 100);
    add(0, 1, 7, 0, 0, 100);
    add(0, 0, 0, 0, 1, 7);
    add(0, 1, 5, 15, 0, 7);
    add(0, 0, 0, 15, 1, 129);
    add(0, 0, 0, 15, 0, 129);
    add(1, 0, 0, 8, 0, 0);
    for (int k = 0; k < 8; k++) add(0, 1, 'h8000, 8, 0, 0);
    add(0, 0, 0, 8, 1, 'h40000);
    add(1, 0, 0, 8, 0, 0);
    for (int k = 0; k < 8; k++) add(0, 1, 'h7FFF, 8, 0, 0);
    add(0, 0, 0, 8, 1, 262136);
    add(0, 0, 0, 8, 0, 262136);
    add(1, 0, 0, 8, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, 1, k, 8, 0, 0);
    add(1, 1, 6, 8, 0, 0);
    for (int k = 11; k <= 18; k++) add(0, 1, k, 8, 0, 0);
    add(0, 0, 0, 8, 1, 116);
    add(1, 0, 0, 8, 0, 0);
    for (int k = 0; k < 8; k++) add(0, 1, 'hFFFF, 8, 0, 0);
    add(0, 0, 0, 8, 1, 524280);
    add(1, 0, 0, 8, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      add(0, 1, k, 8, 0, (k - 1 >= 8) ? 8 * (k - 1) - 28 : 0);
      add(0, 0, 0, 8, k >= 8, (k >= 8) ? 8 * k - 28 : 0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].iv, int'(tbl[i].a), int'(tbl[i].len));
      chk($sformatf("tbl%0d_ov", i), longint'(if0.out_valid), longint'(tbl[i].ov));
      chk($sformatf("tbl%0d_s", i),  longint'(if0.s), longint'(tbl[i].s));
    end

    step(1, 0, 0, 8);
    for (int i = 0; i < 1500; i++) begin
      logic r;
      logic v;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      step(r, v, int'($urandom_range(0, 65535)), int'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
